// File: rtl/axi_request_responder.sv
`timescale 1ns/1ps
// Request queue: push when not full, pop data visible combinationally at the head.
// Occupancy is registered, so a pop frees its slot only from the next cycle.
module axi_request_responder_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         i_push,
    input  logic [W-1:0] i_push_dat,
    input  logic         i_pop,
    output logic [W-1:0] o_pop_dat,
    output logic         o_full,
    output logic         o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]   r_count;
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [W-1:0]  r_mem [DEPTH];

    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_pop_dat = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            // DEPTH is a power of two, so the pointers wrap by plain overflow.
            if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_push_dat;
    end
endmodule

// Far-end responder: each queued request ID yields ROW_BEATS tagged beats, then a completion pulse.
// First beat two cycles after the request handshake; TX beats are held while TREADY is low.
module axi_request_responder #(
    parameter int ROW_BEATS  = 32,
    parameter int FIFO_DEPTH = 16
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic [255:0] AXIS_RX_TDATA,
    input  logic         AXIS_RX_TVALID,
    input  logic         AXIS_RX_TLAST,
    output logic         AXIS_RX_TREADY,
    output logic [255:0] AXIS_TX_TDATA,
    output logic         AXIS_TX_TVALID,
    output logic         AXIS_TX_TLAST,
    input  logic         AXIS_TX_TREADY,
    output logic         row_complete_out,
    output logic [31:0]  rows_served,
    output logic         busy
);
    typedef enum logic {S_IDLE, S_STREAM} state_t;

    localparam logic [15:0] LAST_IDX   = 16'(ROW_BEATS - 1);
    localparam logic        FIRST_LAST = (ROW_BEATS == 1);

    state_t      r_state;
    logic        r_rx_en;
    logic [31:0] r_cur_req;
    logic [15:0] r_beat_idx;
    logic        r_tx_vld;
    logic        r_tx_last;
    logic        r_row_done;
    logic [31:0] r_rows_served;

    logic        w_full;
    logic        w_empty;
    logic        w_push;
    logic        w_pop;
    logic        w_tx_hs;
    logic        w_row_end;
    logic [31:0] w_head;
    logic        w_unused;

    assign w_unused = ^{AXIS_RX_TDATA[255:32], AXIS_RX_TLAST};

    // r_rx_en keeps TREADY low throughout reset even though the FIFO reads empty.
    assign AXIS_RX_TREADY = r_rx_en & ~w_full;
    assign w_push         = AXIS_RX_TVALID & AXIS_RX_TREADY;
    assign w_tx_hs        = r_tx_vld & AXIS_TX_TREADY;
    assign w_row_end      = w_tx_hs & r_tx_last;
    assign w_pop          = ~w_empty & ((r_state == S_IDLE) | w_row_end);

    axi_request_responder_fifo #(
        .W     (32),
        .DEPTH (FIFO_DEPTH)
    ) u_req_fifo (
        .clk        (clk),
        .resetn     (resetn),
        .i_push     (w_push),
        .i_push_dat (AXIS_RX_TDATA[31:0]),
        .i_pop      (w_pop),
        .o_pop_dat  (w_head),
        .o_full     (w_full),
        .o_empty    (w_empty)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state       <= S_IDLE;
            r_rx_en       <= 1'b0;
            r_cur_req     <= '0;
            r_beat_idx    <= '0;
            r_tx_vld      <= 1'b0;
            r_tx_last     <= 1'b0;
            r_row_done    <= 1'b0;
            r_rows_served <= '0;
        end else begin
            r_rx_en    <= 1'b1;
            r_row_done <= w_row_end;
            if (w_row_end) r_rows_served <= r_rows_served + 32'd1;
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_state    <= S_STREAM;
                        r_cur_req  <= w_head;
                        r_beat_idx <= '0;
                        r_tx_vld   <= 1'b1;
                        r_tx_last  <= FIRST_LAST;
                    end
                end
                S_STREAM: begin
                    if (w_row_end && w_pop) begin
                        // Next request already queued: start its row with no bubble.
                        r_cur_req  <= w_head;
                        r_beat_idx <= '0;
                        r_tx_last  <= FIRST_LAST;
                    end else if (w_row_end) begin
                        r_state   <= S_IDLE;
                        r_tx_vld  <= 1'b0;
                        r_tx_last <= 1'b0;
                    end else if (w_tx_hs) begin
                        r_beat_idx <= r_beat_idx + 16'd1;
                        r_tx_last  <= ((r_beat_idx + 16'd1) == LAST_IDX);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign AXIS_TX_TVALID   = r_tx_vld;
    assign AXIS_TX_TLAST    = r_tx_last;
    assign AXIS_TX_TDATA    = r_tx_vld ? {192'd0, 16'hC0DE, r_beat_idx, r_cur_req} : 256'd0;
    assign row_complete_out = r_row_done;
    assign rows_served      = r_rows_served;
    assign busy             = (r_state == S_STREAM) | ~w_empty;
endmodule
